dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning byte-address width; capacity 2**ADDR_W bytes.
REQ-002 SHALL have parameter DEPTH_BYTES, default 1024, meaning implemented bytes; must be at most 2**ADDR_W and a multiple of 4.
REQ-003 SHALL have parameter LATENCY, default 1, meaning read/write response latency in cycles; legal range 1..4.
REQ-004 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; synchronous and active-low.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  block can accept a request.
REQ-008 SHALL have port req_we  in  1  1=store, 0=load.
REQ-009 SHALL have port req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-010 SHALL have port req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0.
REQ-011 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-012 SHALL have port req_wdata  in  32  store data, right-justified.
REQ-013 SHALL have port rsp_valid  out  1  response present.
REQ-014 SHALL have port rsp_ready  in  1  consumer accepts response.
REQ-015 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-016 SHALL have port rsp_err  out  1  access was misaligned, illegal-size or out-of-range.
REQ-017 SHALL have port err_count  out  8  saturating count of errored requests.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE.
REQ-020 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, then move to WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-021 SHALL, in WAIT, count down so that rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until an edge with rsp_ready=1, then return to IDLE; req_ready is next high the cycle after that edge.
REQ-023 SHALL permit at most one outstanding request (no accept while in WAIT or RESP).
REQ-024 SHALL flag an error for any of: req_size=11; half with addr[0]=1; word with addr[1:0]!=0; addr+bytes-1 >= DEPTH_BYTES.
REQ-025 SHALL store little-endian on a non-error store at the accept edge: byte at addr gets wdata[7:0]; half writes addr..addr+1; word writes addr..addr+3; other bytes unchanged.
REQ-026 SHALL NOT modify memory on an errored request.
REQ-027 SHALL capture load data little-endian at the accept edge.
REQ-028 SHALL, for loads, set rsp_rdata bits above the access size to 0 if req_unsigned=1, else to copies of the access MSB.
REQ-029 SHALL increment err_count by 1 on each accepted errored request, saturating at 255.
REQ-030 SHALL leave memory contents unaffected by reset; unwritten bytes read as X in simulation.

Reset
REQ-031 SHALL, on an edge with rst_n=0, force the FSM to IDLE and drive rsp_valid=0, rsp_rdata=0, rsp_err=0 and err_count=0; req_ready is 1 after reset.
REQ-032 SHALL give reset priority over a simultaneous req_valid: no accept and no write on that edge.
REQ-033 SHALL, on reset during WAIT or RESP, discard the pending response; a store committed at its accept edge remains in memory.

Verification (LATENCY=2)
REQ-034 SHALL pass: word store 0x01234567 @0x004, then word load @0x004 -> rsp_valid 2 cycles after accept, rdata=0x01234567, err=0.
REQ-035 SHALL pass: byte store 0x80 @0x008, then signed byte load @0x008 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; half load @0x008 after word 0 store -> 0x00000080.
REQ-036 SHALL pass: word store @0x006 -> rsp_err=1 with rdata=0, memory @0x004..0x007 unchanged, err_count=1; a size=11 request -> err_count=2.
REQ-037 SHALL pass: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; req_ready=1 the cycle after rsp_ready=1.
REQ-038 SHALL pass: rst_n=0 in WAIT -> next cycle rsp_valid=0, req_ready=1, err_count=0, no response emitted.
REQ-039 SHALL pass: 300 errored requests -> err_count=255.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding byte-addressed data memory with sized, sign/zero-extended access
module dmem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        err_count
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic [7:0] mem [DEPTH_BYTES];
  logic acc, err;
  logic [1:0] off;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [ADDR_W:0] last;
  logic [31:0] raw, ld;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign acc = req_valid && req_ready;
  // byte lanes, range/alignment check and extended load data for the presented request
  always_comb begin
    a1 = req_addr + ADDR_W'(1);
    a2 = req_addr + ADDR_W'(2);
    a3 = req_addr + ADDR_W'(3);
    off = req_size == 2'd2 ? 2'd3 : {1'b0, req_size[0]};
    last = {1'b0, req_addr} + (ADDR_W+1)'(off);
    err = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
          (req_size == 2'd2 && req_addr[1:0] != 2'd0) || last >= (ADDR_W+1)'(DEPTH_BYTES);
    raw = {mem[a3], mem[a2], mem[a1], mem[req_addr]};
    ld = req_size == 2'd0 ? {{24{~req_unsigned & raw[7]}}, raw[7:0]} :
         req_size == 2'd1 ? {{16{~req_unsigned & raw[15]}}, raw[15:0]} : raw;
  end
  // state register and latency countdown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 2'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end
  // next state: accept -> WAIT/RESP, count down in WAIT, leave RESP on rsp_ready
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == IDLE && req_valid) begin
      state_nx = LATENCY == 1 ? RESP : WAIT;
      cnt_nx = 2'(LATENCY - 2);
    end else if (state == WAIT) begin
      state_nx = cnt == 2'd0 ? RESP : WAIT;
      cnt_nx = cnt - 2'd1;
    end else if (state == RESP && rsp_ready) begin
      state_nx = IDLE;
    end
  end
  // response payload and saturating error counter, captured at the accept edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
      err_count <= 8'd0;
    end else if (acc) begin
      rsp_err <= err;
      rsp_rdata <= (err || req_we) ? 32'd0 : ld;
      if (err && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end
  // little-endian store of the sized access; memory itself is never reset
  always_ff @(posedge clk) begin
    if (rst_n && acc && req_we && !err) begin
      mem[req_addr] <= req_wdata[7:0];
      if (req_size != 2'd0) mem[a1] <= req_wdata[15:8];
      if (req_size == 2'd2) begin
        mem[a2] <= req_wdata[23:16];
        mem[a3] <= req_wdata[31:24];
      end
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized check of dmem_ctrl against a byte-array reference model
module tb_dmem_ctrl;
  localparam int AW = 10, DEPTH = 1000, LAT = 2;
  logic clk = 0, rst_n = 0, req_valid = 0, req_we = 0, req_unsigned = 0, rsp_ready = 0;
  logic [1:0] req_size = 0;
  logic [AW-1:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0] err_count;
  int checks = 0, failures = 0, errs = 0;
  logic [7:0] model [DEPTH];

  dmem_ctrl #(.ADDR_W(AW), .DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input int addr, input logic [31:0] wd, input int hold);
    int n, k;
    bit e;
    longint v;
    logic [31:0] er;
    n = 1 << sz;
    v = 0;
    er = 0;
    e = sz == 2'd3 || addr % n != 0 || addr + n - 1 >= DEPTH;
    if (!e && !we) begin
      for (int i = 0; i < n; i++) v = v | (longint'(model[addr+i]) << (8 * i));
      if (!uns && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      er = v[31:0];
    end
    if (!e && we) for (int i = 0; i < n; i++) model[addr+i] = wd[8*i+:8];
    if (e) errs = errs < 255 ? errs + 1 : 255;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = AW'(addr); req_wdata = wd;
    @(negedge clk);
    req_valid = 0;
    k = 0;
    while (!rsp_valid && k < 20) begin
      chk("req_ready_busy", req_ready, 0);
      @(negedge clk);
      k++;
    end
    chk("latency", k, LAT - 1);
    chk("rdata", rsp_rdata, er);
    chk("err", rsp_err, e);
    chk("err_count", err_count, errs);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, er);
      chk("hold_err", rsp_err, e);
      chk("hold_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("done_valid", rsp_valid, 0);
    chk("done_ready", req_ready, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_errcnt", err_count, 0);
    rst_n = 1;
    for (int a = 0; a < DEPTH; a += 4) do_req(1, 2, 0, a, $urandom, 0);
    do_req(1, 2, 0, 4, 32'h01234567, 0);
    do_req(0, 2, 0, 4, 0, 0);
    chk("word_load_const", rsp_rdata, 32'h01234567);
    do_req(1, 2, 0, 8, 0, 0);
    do_req(1, 0, 0, 8, 32'h80, 0);
    do_req(0, 0, 0, 8, 0, 0);
    do_req(0, 0, 1, 8, 0, 0);
    do_req(0, 1, 0, 8, 0, 0);
    do_req(1, 2, 0, 6, 32'hFFFFFFFF, 0);
    do_req(0, 2, 0, 4, 0, 0);
    do_req(0, 3, 0, 0, 0, 0);
    chk("errcnt_two", err_count, 2);
    do_req(0, 2, 1, 4, 0, 5);
    do_req(1, 2, 0, 996, 32'h11223344, 0);
    do_req(1, 1, 0, 998, 32'h5566, 0);
    do_req(0, 2, 0, 996, 0, 0);
    do_req(0, 1, 0, 999, 0, 0);
    do_req(0, 0, 0, 1000, 0, 0);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2; req_addr = AW'(16); req_wdata = 32'hCAFEBABE;
    for (int i = 0; i < 4; i++) model[16+i] = req_wdata[8*i+:8];
    @(negedge clk);
    req_valid = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1; errs = 0;
    chk("rstw_valid", rsp_valid, 0);
    chk("rstw_ready", req_ready, 1);
    chk("rstw_errcnt", err_count, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rstw_noresp", rsp_valid, 0);
    end
    do_req(0, 2, 0, 16, 0, 0);
    @(negedge clk);
    rst_n = 0; req_valid = 1; req_we = 1; req_size = 2; req_addr = AW'(32); req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    rst_n = 1; req_valid = 0;
    chk("rstp_valid", rsp_valid, 0);
    chk("rstp_ready", req_ready, 1);
    do_req(0, 2, 0, 32, 0, 0);
    for (int i = 0; i < 200; i++)
      do_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
             $urandom_range(0, (1 << AW) - 1), $urandom, $urandom_range(0, 2));
    for (int i = 0; i < 300; i++)
      do_req($urandom_range(0, 1), 2'd2, 0, 4 * $urandom_range(0, 200) + $urandom_range(1, 3), $urandom, 0);
    chk("errcnt_sat", err_count, 255);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
